// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative unsigned shift-add multiplier / restoring divider, one bit per cycle
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       funct,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0] fn;
  logic [WIDTH-1:0] opnd, diff;
  logic [2*WIDTH-1:0] acc, acc_n;
  logic [WIDTH:0] sum, tmp;
  logic last, ge, accept;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    last = cnt == CW'(WIDTH - 1);
    state_n = (state == IDLE) ? (start ? RUN : IDLE) :
              (state == RUN)  ? (last ? FIN : RUN) : IDLE;
  end
  always_comb begin
    busy = state != IDLE;
    done = state == FIN;
    accept = start && state == IDLE;
    stall = accept || busy;
  end
  // acc holds {hi, lo} of the product for multiply, {remainder, dividend/quotient} for divide
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    tmp = acc[2*WIDTH-1:WIDTH-1];
    ge = tmp >= {1'b0, opnd};
    diff = tmp[WIDTH-1:0] - opnd;
    acc_n = fn[1] ? {ge ? diff : tmp[WIDTH-1:0], acc[WIDTH-2:0], ge}
                  : {sum, acc[WIDTH-1:1]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      fn <= '0;
      opnd <= '0;
      acc <= '0;
      result <= '0;
    end else if (accept) begin
      cnt <= '0;
      fn <= funct;
      opnd <= funct[1] ? op2 : op1;
      acc <= {{WIDTH{1'b0}}, funct[1] ? op1 : op2};
    end else if (state == RUN) begin
      cnt <= cnt + CW'(1);
      acc <= acc_n;
      if (last) result <= fn[0] ? acc_n[2*WIDTH-1:WIDTH] : acc_n[WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized and directed checks of mul_div_unit against an arithmetic model
module tb_mul_div_unit;
  logic clk = 0, rst = 1, start = 0, busy, done, stall;
  logic [1:0] funct = 0;
  logic [31:0] op1 = 0, op2 = 0, result;
  int checks = 0, failures = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct(funct), .op1(op1), .op2(op2),
    .busy(busy), .done(done), .stall(stall), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(logic [1:0] f, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (f)
      2'd0: return p[31:0];
      2'd1: return p[63:32];
      2'd2: return (b == 0) ? 32'hFFFFFFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // drives one single-cycle START and scrambles inputs afterwards; lat=-1 if DONE never came
  task automatic do_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    @(posedge clk); #1;
    funct = f; op1 = a; op2 = b; start = 1;
    lat = -1; res = 'x;
    for (int c = 1; c <= 100 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 0;
      op1 = $urandom; op2 = $urandom; funct = 2'($urandom_range(0, 3));
      if (done) begin lat = c; res = result; end
    end
  endtask

  task automatic test_reset;
    rst = 1; start = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    rst = 0;
    @(posedge clk); #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL idle_stall got=%b exp=0", stall); end
    start = 1; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL idle_start_stall got=%b exp=1", stall); end
    start = 0; #1;
  endtask

  task automatic test_latency;
    logic eb, ed, es;
    @(posedge clk); #1;
    funct = 2'd0; op1 = 7; op2 = 6; start = 1; #1;
    checks++;
    if (stall !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL lat_cycle0 got=stall%b/busy%b/done%b exp=1/0/0", stall, busy, done);
    end
    for (int c = 1; c <= 36; c++) begin
      @(posedge clk); #1;
      start = 0;
      eb = c <= 33; ed = c == 33; es = c <= 33;
      checks++;
      if (busy !== eb || done !== ed || stall !== es) begin
        failures++;
        $display("FAIL lat_cycle%0d got=busy%b/done%b/stall%b exp=%b/%b/%b", c, busy, done, stall, eb, ed, es);
      end
      if (c == 33) begin
        checks++; if (result !== 32'h2A) begin failures++; $display("FAIL mul7x6 got=%h exp=0000002a", result); end
      end
    end
  endtask

  task automatic test_directed;
    logic [1:0] tf[10] = '{0, 0, 1, 2, 3, 2, 3, 2, 3, 2};
    logic [31:0] ta[10] = '{7, 32'hFFFFFFFF, 32'hFFFFFFFF, 100, 100, 32'h12345678, 32'h12345678, 5, 5, 32'hFFFFFFFF};
    logic [31:0] tb[10] = '{6, 32'hFFFFFFFF, 32'hFFFFFFFF, 7, 7, 0, 0, 10, 10, 1};
    logic [31:0] te[10] = '{32'h2A, 1, 32'hFFFFFFFE, 32'hE, 2, 32'hFFFFFFFF, 32'h12345678, 0, 5, 32'hFFFFFFFF};
    logic [31:0] r;
    int lat;
    for (int i = 0; i < 10; i++) begin
      do_op(tf[i], ta[i], tb[i], r, lat);
      checks++;
      if (r !== te[i]) begin failures++; $display("FAIL directed%0d f=%0d got=%h exp=%h", i, tf[i], r, te[i]); end
      checks++;
      if (lat != 33) begin failures++; $display("FAIL directed%0d_latency got=%0d exp=33", i, lat); end
    end
  endtask

  task automatic test_random;
    logic [1:0] f;
    logic [31:0] a, b, r, e;
    int lat, sel;
    for (int i = 0; i < 40; i++) begin
      f = 2'($urandom_range(0, 3));
      a = (i % 8 == 0) ? 32'hFFFFFFFF : $urandom;
      sel = $urandom_range(0, 3);
      b = (sel == 0) ? 32'h0 : (sel == 1) ? 32'($urandom_range(1, 15)) : $urandom;
      e = ref_model(f, a, b);
      do_op(f, a, b, r, lat);
      checks++;
      if (r !== e || lat != 33) begin
        failures++; $display("FAIL random%0d f=%0d a=%h b=%h got=%h/lat%0d exp=%h/lat33", i, f, a, b, r, lat, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    int ndone = 0;
    @(posedge clk); #1;
    funct = 2'd2; op1 = 1000; op2 = 3; start = 1;
    for (int c = 1; c <= 75; c++) begin
      @(posedge clk); #1;
      if (c < 33 || c >= 35) begin op1 = $urandom; op2 = $urandom; funct = 2'($urandom_range(0, 3)); end
      if (c == 33) begin funct = 2'd2; op1 = 50; op2 = 5; end
      if (c == 35) start = 0;
      if (c == 34) begin
        checks++;
        if (stall !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL b2b_restart got=stall%b/busy%b exp=1/0", stall, busy); end
      end
      if (done) begin
        ndone++;
        checks++;
        if (c == 33) begin
          if (result !== 32'd333) begin failures++; $display("FAIL b2b_first got=%h exp=%h", result, 32'd333); end
        end else if (c == 67) begin
          if (result !== 32'd10) begin failures++; $display("FAIL b2b_second got=%h exp=%h", result, 32'd10); end
        end else begin
          failures++; $display("FAIL b2b_stray_done got=cycle%0d exp=cycle33_or_67", c);
        end
      end
      if (c == 72) begin
        checks++;
        if (result !== 32'd10) begin failures++; $display("FAIL b2b_hold got=%h exp=%h", result, 32'd10); end
      end
    end
    checks++;
    if (ndone != 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", ndone); end
  endtask

  task automatic test_reset_midop;
    logic [31:0] r;
    int lat;
    @(posedge clk); #1;
    funct = 2'd2; op1 = 32'h12345678; op2 = 7; start = 1;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 0;
      rst = (c == 10);
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL rst_mid_done cycle%0d got=%b exp=0", c, done); end
      if (c >= 11) begin
        checks++;
        if (busy !== 1'b0 || result !== 32'h0) begin
          failures++; $display("FAIL rst_mid_state cycle%0d got=busy%b/%h exp=0/00000000", c, busy, result);
        end
      end
    end
    do_op(2'd2, 100, 7, r, lat);
    checks++;
    if (r !== 32'hE || lat != 33) begin failures++; $display("FAIL rst_mid_recover got=%h/lat%0d exp=0000000e/lat33", r, lat); end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_directed;
    test_random;
    test_back_to_back;
    test_reset_midop;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
